banco_registradores: RTL and testbench
======================================

// Module: banco_registradores
// PURPOSE
//  - Register file of the 16-bit MIPS datapath; direct upstream of the ULA, driving its a/b operand inputs.
//  - Two read ports and one write port. Outputs are registered operand latches (A/B), as in the multicycle datapath.
//  - Write-back from the ULA result path (or from memory) enters through the write port.
// PARAMETERS
//  DATA_W  16  word width; must equal the ULA operand width
//  ADDR_W  3   register index width
//  NREGS   8   register count (2**ADDR_W); r0 is hardwired zero
// PORTS
//  clk      in   1       single clock; all state updates on rising edge
//  rst_n    in   1       synchronous, active-low reset
//  rd_en    in   1       request: latch operands selected by rs/rt
//  rs       in   ADDR_W  read address, port A
//  rt       in   ADDR_W  read address, port B
//  wr_en    in   1       write enable
//  rd       in   ADDR_W  write address
//  wr_data  in   DATA_W  write data (ULA result / memory data)
//  a        out  DATA_W  latched operand A -> ULA a
//  b        out  DATA_W  latched operand B -> ULA b
//  ab_valid out  1       one-cycle pulse: a/b updated this cycle
//  a_zero   out  1       registered (a == 0); precomputed for branch logic
// BEHAVIOUR
//  - Reset (rst_n == 0 at a rising edge): all NREGS entries, a, b, ab_valid and a_zero go to 0.
//    Reset overrides any rd_en/wr_en in the same cycle.
//  - Write: wr_en=1 and rd!=0 at edge N -> regs[rd]=wr_data. A write to r0 is ignored.
//  - Read: rd_en=1 at edge N -> a, b and a_zero take new values, and ab_valid=1, after edge N.
//    Latency is one cycle. With rd_en=0, a/b/a_zero hold and ab_valid=0.
//  - Bypass: if wr_en=1, rd!=0 and rd==rs (or rd==rt) in the same cycle as rd_en=1,
//    the latch takes wr_data (write-through) rather than the stale entry.
//  - rs==0 or rt==0 always yields 0, including when the bypass condition names r0.
//  - rs==rt is legal: both a and b get the same value.
//  - Simultaneous read and write to different addresses: both complete, independently.
//  - Reset mid-operation: a pending rd_en is dropped and no ab_valid follows.
//  - Width rule: no arithmetic. Data passes unmodified. Addresses are used modulo NREGS
//    (no out-of-range access is possible).
//  - Two-state controller for ab_valid: IDLE -(rd_en)-> LOAD -(always)-> IDLE, or LOAD again if rd_en.
//    Back-to-back rd_en keeps ab_valid high every cycle.
// STRUCTURE
//  - Shared package mips_pkg: DATA_W=16, ADDR_W=3, REG_ZERO=3'd0, and the ULA control codes
//    (3-bit ula_control) that are shared with the ULA and the control unit.
//  - One natural sub-module: reg_bypass_mux (address compare plus r0 force-zero). It is instantiated once per read port.
//  - Storage is a flat reg array. No latches; no asynchronous reset.
// TESTING (tb_banco_registradores, 2 ns clock, $monitor plus self-check)
//  1. Reset: hold rst_n=0 for 2 cycles, then read rs=1, rt=7 -> a=0, b=0, a_zero=1, ab_valid pulse.
//  2. Write then read: write r1=16'd8, r2=16'd3; then rd_en with rs=1, rt=2
//     -> a=8, b=3, ab_valid=1 exactly one cycle after.
//  3. r0 protection: write r0=16'hFFFF, then read rs=0 -> a=0, a_zero=1.
//  4. Bypass: in one cycle, wr_en with rd=3 and wr_data=16'h1234, plus rd_en with rs=3, rt=3
//     -> a=b=16'h1234 next cycle.
//  5. Back-to-back reads over 3 cycles (rs=1,2,1) -> ab_valid high for 3 cycles; a=8,3,8.
//  6. Mid-op reset: rd_en=1 together with rst_n=0 -> a=0, ab_valid stays 0,
//     and a read of r1 after reset returns 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: widths, r0 index, ab_valid controller states and ULA control codes shared across the 16-bit MIPS datapath
package mips_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] REG_ZERO = 3'd0;
  typedef enum logic {RF_IDLE, RF_LOAD} rf_state_e;
  typedef enum logic [2:0] {
    ULA_AND = 3'b000,
    ULA_OR  = 3'b001,
    ULA_ADD = 3'b010,
    ULA_SUB = 3'b110,
    ULA_SLT = 3'b111
  } ula_control_e;
endpackage

// File: rtl/banco_registradores_if.sv
// banco_registradores_if: register file bus (rd_en/rs/rt read request, wr_en/rd/wr_data write, a/b/ab_valid/a_zero operands); master drives requests, slave is the register file
interface banco_registradores_if;
  import mips_pkg::*;
  logic              rd_en;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic              wr_en;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              ab_valid;
  logic              a_zero;
  modport master (output rd_en, rs, rt, wr_en, rd, wr_data, input a, b, ab_valid, a_zero);
  modport slave (input rd_en, rs, rt, wr_en, rd, wr_data, output a, b, ab_valid, a_zero);
endinterface

// File: rtl/reg_bypass_mux.sv
// reg_bypass_mux: read-port operand select (raddr_i, entry_i, wr_en_i, waddr_i, wdata_i -> data_o); r0 forces zero, same-cycle write to raddr passes wdata through
module reg_bypass_mux
  import mips_pkg::*;
(
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [DATA_W-1:0] entry_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] data_o
);
  always_comb data_o = (raddr_i == REG_ZERO) ? '0 : (wr_en_i && waddr_i == raddr_i) ? wdata_i : entry_i;
endmodule

// File: rtl/banco_registradores.sv
// banco_registradores: 8x16 register file (clk, rst_n sync active-low, bus slave) with registered A/B operand latches, write-through bypass, ab_valid pulse and a_zero flag
module banco_registradores
  import mips_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  banco_registradores_if.slave bus
);
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] a_q, b_q, a_d, b_d;
  logic              a_zero_q;
  rf_state_e         state_q;
  reg_bypass_mux u_mux_a (
    .raddr_i(bus.rs), .entry_i(regs_q[bus.rs]), .wr_en_i(bus.wr_en),
    .waddr_i(bus.rd), .wdata_i(bus.wr_data), .data_o(a_d)
  );
  reg_bypass_mux u_mux_b (
    .raddr_i(bus.rt), .entry_i(regs_q[bus.rt]), .wr_en_i(bus.wr_en),
    .waddr_i(bus.rd), .wdata_i(bus.wr_data), .data_o(b_d)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      a_q      <= '0;
      b_q      <= '0;
      a_zero_q <= 1'b0;
      state_q  <= RF_IDLE;
    end else begin
      if (bus.wr_en && bus.rd != REG_ZERO) regs_q[bus.rd] <= bus.wr_data;
      if (bus.rd_en) begin
        a_q      <= a_d;
        b_q      <= b_d;
        a_zero_q <= (a_d == '0);
      end
      state_q <= bus.rd_en ? RF_LOAD : RF_IDLE;
    end
  end
  assign bus.a        = a_q;
  assign bus.b        = b_q;
  assign bus.a_zero   = a_zero_q;
  assign bus.ab_valid = (state_q == RF_LOAD);
endmodule

// File: tb/tb_banco_registradores.sv
// tb_banco_registradores: directed self-checking bench for banco_registradores
`timescale 1ns/1ps
module tb_banco_registradores;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  banco_registradores_if bus ();
  banco_registradores dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #1 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic re, input logic [2:0] s, input logic [2:0] t,
                     input logic we, input logic [2:0] d, input logic [15:0] wd);
    bus.rd_en = re;
    bus.rs = s;
    bus.rt = t;
    bus.wr_en = we;
    bus.rd = d;
    bus.wr_data = wd;
    @(negedge clk);
  endtask
  task automatic chk_ab(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                        input logic ev, input logic ez);
    chk({tag, ".a"}, {16'h0, bus.a}, {16'h0, ea});
    chk({tag, ".b"}, {16'h0, bus.b}, {16'h0, eb});
    chk({tag, ".valid"}, {31'h0, bus.ab_valid}, {31'h0, ev});
    chk({tag, ".zero"}, {31'h0, bus.a_zero}, {31'h0, ez});
  endtask
  initial begin
    $monitor("t=%0t rst_n=%b a=%h b=%h ab_valid=%b a_zero=%b", $time, rst_n, bus.a, bus.b, bus.ab_valid, bus.a_zero);
    rst_n = 1'b0;
    cyc(1'b1, 3'd1, 3'd2, 1'b1, 3'd1, 16'hAAAA);
    cyc(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0);
    chk_ab("reset", 16'h0, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b1, 3'd1, 3'd7, 1'b0, 3'd0, 16'h0);
    chk_ab("post_reset_read", 16'h0, 16'h0, 1'b1, 1'b1);
    cyc(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0);
    chk("post_reset_idle.valid", {31'h0, bus.ab_valid}, 32'h0);
    cyc(1'b0, 3'd0, 3'd0, 1'b1, 3'd1, 16'd8);
    cyc(1'b0, 3'd0, 3'd0, 1'b1, 3'd2, 16'd3);
    chk("write_no_read.valid", {31'h0, bus.ab_valid}, 32'h0);
    cyc(1'b1, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0);
    chk_ab("read_r1_r2", 16'd8, 16'd3, 1'b1, 1'b0);
    cyc(1'b0, 3'd3, 3'd3, 1'b0, 3'd0, 16'h0);
    chk_ab("hold", 16'd8, 16'd3, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 16'hFFFF);
    cyc(1'b1, 3'd0, 3'd1, 1'b0, 3'd0, 16'h0);
    chk_ab("r0_protect", 16'h0, 16'd8, 1'b1, 1'b1);
    cyc(1'b1, 3'd3, 3'd3, 1'b1, 3'd3, 16'h1234);
    chk_ab("bypass_r3", 16'h1234, 16'h1234, 1'b1, 1'b0);
    cyc(1'b1, 3'd0, 3'd0, 1'b1, 3'd0, 16'hFFFF);
    chk_ab("bypass_r0", 16'h0, 16'h0, 1'b1, 1'b1);
    cyc(1'b1, 3'd3, 3'd2, 1'b1, 3'd4, 16'hBEEF);
    chk_ab("rw_diff_addr", 16'h1234, 16'd3, 1'b1, 1'b0);
    cyc(1'b1, 3'd4, 3'd0, 1'b0, 3'd0, 16'h0);
    chk_ab("read_r4", 16'hBEEF, 16'h0, 1'b1, 1'b0);
    cyc(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0);
    cyc(1'b1, 3'd1, 3'd0, 1'b0, 3'd0, 16'h0);
    chk_ab("b2b_0", 16'd8, 16'h0, 1'b1, 1'b0);
    cyc(1'b1, 3'd2, 3'd0, 1'b0, 3'd0, 16'h0);
    chk_ab("b2b_1", 16'd3, 16'h0, 1'b1, 1'b0);
    cyc(1'b1, 3'd1, 3'd0, 1'b0, 3'd0, 16'h0);
    chk_ab("b2b_2", 16'd8, 16'h0, 1'b1, 1'b0);
    cyc(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0);
    chk("b2b_end.valid", {31'h0, bus.ab_valid}, 32'h0);
    rst_n = 1'b0;
    cyc(1'b1, 3'd1, 3'd2, 1'b1, 3'd5, 16'h5555);
    chk_ab("midop_reset", 16'h0, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0);
    chk("midop_after.valid", {31'h0, bus.ab_valid}, 32'h0);
    cyc(1'b1, 3'd1, 3'd5, 1'b0, 3'd0, 16'h0);
    chk_ab("read_after_reset", 16'h0, 16'h0, 1'b1, 1'b1);
    $monitoroff;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
